// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   HZ_RUN / HZ_MEM_WAIT : controller state encodings
//   REG_X0               : architectural zero register (never a real hazard source)
//   is_load_use()        : load-use hazard detect between the EX load and the ID consumer
package hazard_control_unit_pkg;

  localparam logic [0:0] HZ_RUN      = 1'b0;
  localparam logic [0:0] HZ_MEM_WAIT = 1'b1;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load in EX whose destination is read by the instruction in ID cannot be
  // forwarded in time; x0 writes are discarded so they never create a hazard.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       uses_rs1,
    input logic       uses_rs2
  );
    return ex_mem_read && (ex_rd != REG_X0) &&
           ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter.
//   clk, reset : clock and synchronous active-high clear
//   inc        : add one this cycle (ignored once the count is all-ones)
//   count      : current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes and data-memory wait states, plus saturating
// stall/flush performance counters.
//   Inputs : ID source regs + use flags, EX rd / load flag / branch-taken,
//            MEM request and data-memory ready.
//   Outputs: PC and pipeline-register enables, IF/ID and ID/EX flushes,
//            mem_wait debug flag, stall_cycles and flush_count counters.
// All control outputs are combinational from the state and current inputs.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_write_en,
  output logic             idex_flush,
  output logic             exmem_write_en,
  output logic             memwb_write_en,
  output logic             mem_wait,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       freeze;
  logic       load_use;
  logic       branch_act;
  logic       stall_inc;

  assign freeze   = mem_req && !dmem_ready;
  assign load_use = is_load_use(ex_MemRead, ex_rd_addr, id_rs1_addr, id_rs2_addr,
                                id_uses_rs1, id_uses_rs2);

  // A branch stuck behind a memory freeze is only acted on in the cycle it
  // actually advances, so it flushes exactly once.
  assign branch_act = !reset && !freeze && ex_branch_taken;

  // Priority: reset > freeze > branch > load-use > normal.
  always_comb begin
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    ifid_flush     = 1'b0;
    idex_write_en  = 1'b1;
    idex_flush     = 1'b0;
    exmem_write_en = 1'b1;
    memwb_write_en = 1'b1;
    if (reset) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      ifid_flush     = 1'b1;
      idex_write_en  = 1'b0;
      idex_flush     = 1'b1;
      exmem_write_en = 1'b0;
      memwb_write_en = 1'b0;
    end else if (freeze) begin
      // Whole pipe holds, MEM/WB included: rewriting the same WB value is
      // harmless and keeps the WB forwarding source stable.
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      idex_write_en  = 1'b0;
      exmem_write_en = 1'b0;
      memwb_write_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // One bubble: next cycle EX holds the bubble, so the hazard clears itself.
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_flush    = 1'b1;
    end
  end

  // Both states leave/enter MEM_WAIT purely on whether an access is
  // outstanding; a dropped mem_req in MEM_WAIT also returns to RUN.
  always_comb begin
    state_d = HZ_RUN;
    if (freeze) begin
      state_d = HZ_MEM_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_wait  = !reset && (state_q == HZ_MEM_WAIT);
  assign stall_inc = !reset && !pc_write_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_act),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios then random traffic,
// checked against a behavioural model. A second instance with 4-bit
// counters shares the inputs to exercise counter saturation.
module tb_hazard_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, memread, br, mreq, rdy;

  logic        pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en, mwait;
  logic [31:0] stall32, flush32;
  logic        pc_en_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_en_b, memwb_en_b, mwait_b;
  logic [3:0]  stall4, flush4;

  hazard_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_uses_rs1(u1), .id_uses_rs2(u2),
    .ex_rd_addr(rd), .ex_MemRead(memread), .ex_branch_taken(br),
    .mem_req(mreq), .dmem_ready(rdy),
    .pc_write_en(pc_en), .ifid_write_en(ifid_en), .ifid_flush(ifid_fl),
    .idex_write_en(idex_en), .idex_flush(idex_fl),
    .exmem_write_en(exmem_en), .memwb_write_en(memwb_en), .mem_wait(mwait),
    .stall_cycles(stall32), .flush_count(flush32)
  );

  hazard_control_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .id_uses_rs1(u1), .id_uses_rs2(u2),
    .ex_rd_addr(rd), .ex_MemRead(memread), .ex_branch_taken(br),
    .mem_req(mreq), .dmem_ready(rdy),
    .pc_write_en(pc_en_b), .ifid_write_en(ifid_en_b), .ifid_flush(ifid_fl_b),
    .idex_write_en(idex_en_b), .idex_flush(idex_fl_b),
    .exmem_write_en(exmem_en_b), .memwb_write_en(memwb_en_b), .mem_wait(mwait_b),
    .stall_cycles(stall4), .flush_count(flush4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model state: whether an access is outstanding, and counter values.
  bit     m_wait;
  longint m_stall, m_flush, m_stall4, m_flush4;

  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;

  // Expected controls packed {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb}.
  function automatic logic [6:0] exp_ctrl();
    bit hazard;
    hazard = memread && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (reset)              return 7'b0010100;
    if (mreq && !rdy)       return 7'b0000000;
    if (br)                 return 7'b1111111;
    if (hazard)             return 7'b0001111;
    return 7'b1101011;
  endfunction

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Inputs must already be driven; checks outputs mid-cycle, advances the
  // model across the next rising edge and checks counters just after it.
  task automatic cycle();
    logic [6:0] e;
    bit frozen;
    @(negedge clk);
    e = exp_ctrl();
    chk("ctrl",   {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en}, e);
    chk("ctrl_b", {pc_en_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_en_b, memwb_en_b}, e);
    chk("mem_wait", mwait, m_wait && !reset);
    frozen = mreq && !rdy;
    if (reset) begin
      m_wait = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    end else begin
      m_wait = frozen;
      if (!e[6]) begin
        m_stall  = sat_inc(m_stall, MAX32);
        m_stall4 = sat_inc(m_stall4, MAX4);
      end
      if (!frozen && br) begin
        m_flush  = sat_inc(m_flush, MAX32);
        m_flush4 = sat_inc(m_flush4, MAX4);
      end
    end
    @(posedge clk);
    #1;
    chk("stall_cycles",   64'(stall32), m_stall);
    chk("flush_count",    64'(flush32), m_flush);
    chk("stall_cycles_4", 64'(stall4),  m_stall4);
    chk("flush_count_4",  64'(flush4),  m_flush4);
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0;
    memread = 0; br = 0; mreq = 0; rdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_wait = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    cycle();
    cycle();
    reset = 0;

    // Load-use via rs1: one bubble, then EX holds the bubble.
    rd = 5; memread = 1; rs1 = 5; u1 = 1; rs2 = 1; u2 = 1;
    cycle();
    chk("t1_stall_one", 64'(stall32), 1);
    memread = 0; rd = 0;
    cycle();

    // No hazard: load to x0, and unused rs2 matching.
    rd = 0; memread = 1; rs1 = 0; u1 = 1;
    cycle();
    rd = 5; rs1 = 1; u1 = 1; rs2 = 5; u2 = 0;
    cycle();
    chk("t2_no_stall", 64'(stall32), 1);

    // Branch wins over load-use.
    do_reset();
    rd = 5; memread = 1; rs1 = 5; u1 = 1; br = 1;
    cycle();
    chk("t3_flush_one", 64'(flush32), 1);
    chk("t3_no_stall",  64'(stall32), 0);

    // Three wait states with a branch held in EX, then release.
    do_reset();
    mreq = 1; rdy = 0; br = 1;
    repeat (3) cycle();
    rdy = 1;
    cycle();
    chk("t4_stall_three", 64'(stall32), 3);
    chk("t4_flush_once",  64'(flush32), 1);
    mreq = 0; br = 0;
    cycle();

    // Reset while waiting on memory.
    do_reset();
    mreq = 1; rdy = 0;
    cycle();
    cycle();
    reset = 1;
    cycle();
    chk("t5_cnt_clear", 64'(stall32), 0);
    reset = 0;
    cycle();
    mreq = 0;
    cycle();

    // Saturation of the 4-bit stall counter.
    do_reset();
    rd = 5; memread = 1; rs1 = 5; u1 = 1;
    repeat (20) cycle();
    chk("t6_sat4",     64'(stall4),  15);
    chk("t6_stall32",  64'(stall32), 20);

    // Random traffic with a small register range to make matches common.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      reset   = ($urandom_range(0, 99) < 2);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      u1      = 1'($urandom_range(0, 1));
      u2      = 1'($urandom_range(0, 1));
      memread = ($urandom_range(0, 99) < 50);
      br      = ($urandom_range(0, 99) < 20);
      mreq    = ($urandom_range(0, 99) < 35);
      rdy     = ($urandom_range(0, 99) < 50);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
